// File: rtl/arb_pkg.sv
// Shared constants for the round-robin select arbiter: sizes, FSM encodings, defaults.
// Timeout feature is enabled by defining ARB_TIMEOUT_EN.
package arb_pkg;

   localparam int unsigned NREQ          = 8;
   localparam int unsigned IDX_W         = 3;
   localparam int unsigned ST_W          = 2;
   localparam int unsigned CNT_W         = 8;
   localparam int unsigned TO_CYCLES_DEF = 64;

   localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
   localparam logic [ST_W-1:0] ST_BUSY = 2'd1;
   localparam logic [ST_W-1:0] ST_GAP  = 2'd2;

   // One-hot decode of a requester index.
   function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] i);
      return NREQ'(1) << i;
   endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational rotating-priority picker: first set req bit at or above ptr, wrapping 7 -> 0.
module rr_pick8
   import arb_pkg::*;
(
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] ptr,
   output logic             any,
   output logic [IDX_W-1:0] idx
);

   logic [IDX_W-1:0] pos;

   // Scan from the farthest offset down so the nearest set bit wins last.
   always_comb begin
      any = 1'b0;
      idx = '0;
      pos = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         pos = ptr + IDX_W'(k);
         if (req[pos]) begin
            any = 1'b1;
            idx = pos;
         end
      end
   end

endmodule

// File: rtl/rr_sel_arbiter.sv
// Round-robin 8-way arbiter with registered index and one-hot select, release turnaround.
// Define ARB_TIMEOUT_EN to add a BUSY watchdog that forces release after TO_CYCLES cycles.
module rr_sel_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned TO_CYCLES = TO_CYCLES_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NREQ-1:0]  req,
   input  logic             done,
   output logic             gnt_valid,
   output logic [IDX_W-1:0] gnt_idx,
   output logic [NREQ-1:0]  gnt_sel,
   output logic             timeout_err
);

   if (TO_CYCLES < 2 || TO_CYCLES > 256) begin : g_bad_to
      $error("rr_sel_arbiter: TO_CYCLES out of range 2..256");
   end

   logic [ST_W-1:0]  state, state_nxt;
   logic [IDX_W-1:0] ptr, ptr_nxt;
   logic [IDX_W-1:0] gnt_idx_nxt;
   logic             gnt_valid_nxt;
   logic [NREQ-1:0]  gnt_sel_nxt;
   logic             timeout_nxt;
   logic             pick_any;
   logic [IDX_W-1:0] pick_idx;
   logic             owner_rel;
   logic             to_hit;

   rr_pick8 u_pick (
      .req (req),
      .ptr (ptr),
      .any (pick_any),
      .idx (pick_idx)
   );

   assign owner_rel = done | ~req[gnt_idx];

`ifdef ARB_TIMEOUT_EN
   logic [CNT_W-1:0] cnt, cnt_nxt;

   assign to_hit = (cnt == CNT_W'(TO_CYCLES - 1));

   // BUSY cycle counter: cleared on grant, counts every BUSY cycle.
   always_comb begin
      cnt_nxt = cnt;
      if (state == ST_IDLE && pick_any) begin
         cnt_nxt = '0;
      end else if (state == ST_BUSY) begin
         cnt_nxt = cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt <= '0;
      else        cnt <= cnt_nxt;
   end
`else
   assign to_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         ptr         <= '0;
         gnt_idx     <= '0;
         gnt_valid   <= 1'b0;
         gnt_sel     <= '0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nxt;
         ptr         <= ptr_nxt;
         gnt_idx     <= gnt_idx_nxt;
         gnt_valid   <= gnt_valid_nxt;
         gnt_sel     <= gnt_sel_nxt;
         timeout_err <= timeout_nxt;
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_nxt     = state;
      ptr_nxt       = ptr;
      gnt_idx_nxt   = gnt_idx;
      gnt_valid_nxt = gnt_valid;
      gnt_sel_nxt   = gnt_sel;
      timeout_nxt   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (pick_any) begin
               gnt_idx_nxt   = pick_idx;
               gnt_valid_nxt = 1'b1;
               gnt_sel_nxt   = onehot(pick_idx);
               state_nxt     = ST_BUSY;
            end
         end
         ST_BUSY: begin
            // A normal release on the timeout cycle suppresses the error pulse.
            if (owner_rel || to_hit) begin
               ptr_nxt       = gnt_idx + IDX_W'(1);
               gnt_valid_nxt = 1'b0;
               gnt_sel_nxt   = '0;
               timeout_nxt   = ~owner_rel & to_hit;
               state_nxt     = ST_GAP;
            end
         end
         ST_GAP: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt     = ST_IDLE;
            gnt_valid_nxt = 1'b0;
            gnt_sel_nxt   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Directed self-checking bench for rr_sel_arbiter (TO_CYCLES=4 for the optional timeout case).
module tb_rr_sel_arbiter;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic       done;
   logic       gnt_valid;
   logic [2:0] gnt_idx;
   logic [7:0] gnt_sel;
   logic       timeout_err;

   int passed;
   int failed;
   int total;

   rr_sel_arbiter #(.TO_CYCLES(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .done        (done),
      .gnt_valid   (gnt_valid),
      .gnt_idx     (gnt_idx),
      .gnt_sel     (gnt_sel),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [2:0] idx,
                          input logic [7:0] sel, input logic terr);
      check({tag, ".valid"}, 8'(gnt_valid), 8'(v));
      check({tag, ".idx"}, 8'(gnt_idx), 8'(idx));
      check({tag, ".sel"}, gnt_sel, sel);
      check({tag, ".terr"}, 8'(timeout_err), 8'(terr));
   endtask

   // Advance one edge and settle before sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      passed = 0;
      failed = 0;
      total  = 0;
      rst_n  = 1'b0;
      req    = 8'h00;
      done   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_out("reset", 1'b0, 3'd0, 8'h00, 1'b0);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         step();
         check("idle.valid", 8'(gnt_valid), 8'h00);
         check("idle.sel", gnt_sel, 8'h00);
      end

      // req=05 from ptr=0: 0, then 2, then wrap to 0.
      req = 8'h05;
      step(); chk_out("r05.g0", 1'b1, 3'd0, 8'h01, 1'b0);
      done = 1'b1;
      step(); chk_out("r05.rel0", 1'b0, 3'd0, 8'h00, 1'b0);
      done = 1'b0;
      step(); chk_out("r05.gap", 1'b0, 3'd0, 8'h00, 1'b0);
      step(); chk_out("r05.g2", 1'b1, 3'd2, 8'h04, 1'b0);
      done = 1'b1;
      step(); chk_out("r05.rel2", 1'b0, 3'd2, 8'h00, 1'b0);
      done = 1'b0;
      step();
      step(); chk_out("r05.g0b", 1'b1, 3'd0, 8'h01, 1'b0);
      done = 1'b1;
      req  = 8'h00;
      step(); chk_out("r05.rel_both", 1'b0, 3'd0, 8'h00, 1'b0);
      done = 1'b0;
      step();
      step(); chk_out("r05.none", 1'b0, 3'd0, 8'h00, 1'b0);

      // All requesting, done held: strict rotation 0..7,0 with grant/gap/idle cadence.
      do_reset();
      req  = 8'hFF;
      done = 1'b1;
      for (int k = 0; k < 9; k++) begin
         step();
         chk_out("ff.grant", 1'b1, 3'(k % 8), 8'h01 << (k % 8), 1'b0);
         step();
         check("ff.gap_valid", 8'(gnt_valid), 8'h00);
         step();
         check("ff.idle_valid", 8'(gnt_valid), 8'h00);
      end
      done = 1'b0;
      req  = 8'h00;

      // Owner withdraws request; ptr advances past it, search wraps.
      do_reset();
      req = 8'h08;
      step(); chk_out("wd.g3", 1'b1, 3'd3, 8'h08, 1'b0);
      step(); chk_out("wd.hold3", 1'b1, 3'd3, 8'h08, 1'b0);
      req = 8'h06;
      step(); chk_out("wd.rel3", 1'b0, 3'd3, 8'h00, 1'b0);
      req = 8'h4E;
      step(); chk_out("wd.gap", 1'b0, 3'd3, 8'h00, 1'b0);
      step(); chk_out("wd.g6", 1'b1, 3'd6, 8'h40, 1'b0);
      req = 8'h0E;
      step(); chk_out("wd.rel6", 1'b0, 3'd6, 8'h00, 1'b0);
      step();
      step(); chk_out("wd.g1wrap", 1'b1, 3'd1, 8'h02, 1'b0);
      req = 8'h00;
      step();
      step();

      // Asynchronous reset in the middle of a grant.
      do_reset();
      req = 8'h20;
      step(); chk_out("rs.g5", 1'b1, 3'd5, 8'h20, 1'b0);
      step(); chk_out("rs.hold5", 1'b1, 3'd5, 8'h20, 1'b0);
      rst_n = 1'b0;
      #1;
      chk_out("rs.async", 1'b0, 3'd0, 8'h00, 1'b0);
      #1;
      rst_n = 1'b1;
      req   = 8'h21;
      step(); chk_out("rs.ptr0", 1'b1, 3'd0, 8'h01, 1'b0);
      req = 8'h00;
      step();
      step();

      do_reset();
      req = 8'h02;
`ifdef ARB_TIMEOUT_EN
      // Watchdog forces release after exactly TO_CYCLES busy cycles.
      for (int c = 0; c < 4; c++) begin
         step();
         chk_out("to.busy", 1'b1, 3'd1, 8'h02, 1'b0);
      end
      step(); chk_out("to.fire", 1'b0, 3'd1, 8'h00, 1'b1);
      step(); chk_out("to.gap", 1'b0, 3'd1, 8'h00, 1'b0);
      step(); chk_out("to.regrant", 1'b1, 3'd1, 8'h02, 1'b0);
`else
      // Without the watchdog the grant is held indefinitely.
      for (int c = 0; c < 12; c++) begin
         step();
         chk_out("hold.busy", 1'b1, 3'd1, 8'h02, 1'b0);
      end
`endif
      req = 8'h00;
      step();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
